// File: rtl/md6_pad_responder.sv
// Device-side Mega Drive 6-button pad model: answers the reader's SELECT line
// and drives the active-low D0..D5 data lines from joystick-ordered buttons.
module md6_pad_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 72000,
  parameter bit          SIX_BUTTON     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] btn,
  input  logic        pad_sel,
  output logic [5:0]  pad_out,
  output logic [2:0]  phase,
  output logic        ext_active
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    PH_0 = 3'd0,
    PH_1 = 3'd1,
    PH_2 = 3'd2,
    PH_3 = 3'd3,
    PH_4 = 3'd4
  } phase_t;

  phase_t        state, state_nx;
  logic          sel_m, sel_s, sel_d;
  logic          fall, expire;
  logic [TW-1:0] tcnt, tcnt_inc, tcnt_nx;
  logic [5:0]    out_nx;

  logic u, d, l, r, a, b, c, x, y, z, s, m;
  assign r = btn[0];
  assign l = btn[1];
  assign d = btn[2];
  assign u = btn[3];
  assign a = btn[4];
  assign b = btn[5];
  assign c = btn[6];
  assign x = btn[7];
  assign y = btn[8];
  assign z = btn[9];
  assign s = btn[10];
  assign m = btn[11];

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_m      <= 1'b1;
      sel_s      <= 1'b1;
      sel_d      <= 1'b1;
      tcnt       <= '0;
      state      <= PH_0;
      pad_out    <= '1;
      phase      <= '0;
      ext_active <= 1'b0;
    end else begin
      sel_m      <= pad_sel;
      sel_s      <= sel_m;
      sel_d      <= sel_s;
      tcnt       <= tcnt_nx;
      state      <= state_nx;
      pad_out    <= out_nx;
      phase      <= state_nx;
      ext_active <= (state_nx == PH_3) && sel_s;
    end
  end

  // Expiry is the cycle the counter reaches its last value; an edge on that
  // same cycle takes priority and restarts the count.
  always_comb begin
    fall     = sel_d & ~sel_s;
    tcnt_inc = (tcnt == T_LAST) ? tcnt : tcnt + TW'(1);
    expire   = (tcnt_inc == T_LAST);
    tcnt_nx  = tcnt_inc;
    state_nx = state;
    if (fall) begin
      tcnt_nx = '0;
      case (state)
        PH_0:    state_nx = PH_1;
        PH_1:    state_nx = PH_2;
        PH_2:    state_nx = SIX_BUTTON ? PH_3 : PH_2;
        default: state_nx = PH_4;
      endcase
    end else if (expire) begin
      state_nx = PH_0;
    end
  end

  // Output uses the next phase so a new SELECT level and its phase appear together.
  always_comb begin
    out_nx = '1;
    if (sel_s) begin
      if (state_nx == PH_3) out_nx = {~c, ~b, ~m, ~x, ~y, ~z};
      else                  out_nx = {~c, ~b, ~r, ~l, ~d, ~u};
    end else begin
      case (state_nx)
        PH_3:    out_nx = {~s, ~a, 4'b0000};
        PH_4:    out_nx = {~s, ~a, 4'b1111};
        default: out_nx = {~s, ~a, 2'b00, ~d, ~u};
      endcase
    end
  end

endmodule

// File: tb/tb_md6_pad_responder.sv
// Directed self-checking bench for md6_pad_responder: 6-button, 3-button and
// short-timeout instances share clock, reset and buttons.
module tb_md6_pad_responder;

  localparam int unsigned TO = 72000;
  localparam int unsigned TO_SHORT = 16;

  localparam logic [11:0] B1       = 12'b1010_1001_0101;
  localparam logic [5:0]  LOW_STD  = 6'b100001;
  localparam logic [5:0]  HIGH_STD = 6'b110101;
  localparam logic [5:0]  LOW_ID   = 6'b100000;
  localparam logic [5:0]  HIGH_EXT = 6'b110010;
  localparam logic [5:0]  LOW4     = 6'b101111;

  localparam logic [5:0] SIX_LOW  [4] = '{LOW_STD, LOW_STD, LOW_ID, LOW4};
  localparam logic [5:0] SIX_HIGH [4] = '{HIGH_STD, HIGH_STD, HIGH_EXT, HIGH_STD};
  localparam logic [2:0] SIX_PH   [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  localparam logic       SIX_EXT  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [2:0] TRI_PH   [4] = '{3'd1, 3'd2, 3'd2, 3'd2};

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] btn;
  logic        pad_sel, sel_t;
  logic [5:0]  pad_out, pad_out3, pad_out_t;
  logic [2:0]  phase, phase3, phase_t;
  logic        ext_active, ext_active3, ext_active_t;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  md6_pad_responder #(.TIMEOUT_CYCLES(TO), .SIX_BUTTON(1'b1)) dut (
    .clk(clk), .reset(reset), .btn(btn), .pad_sel(pad_sel),
    .pad_out(pad_out), .phase(phase), .ext_active(ext_active)
  );

  md6_pad_responder #(.TIMEOUT_CYCLES(TO), .SIX_BUTTON(1'b0)) dut3 (
    .clk(clk), .reset(reset), .btn(btn), .pad_sel(pad_sel),
    .pad_out(pad_out3), .phase(phase3), .ext_active(ext_active3)
  );

  md6_pad_responder #(.TIMEOUT_CYCLES(TO_SHORT), .SIX_BUTTON(1'b1)) dut_t (
    .clk(clk), .reset(reset), .btn(btn), .pad_sel(sel_t),
    .pad_out(pad_out_t), .phase(phase_t), .ext_active(ext_active_t)
  );

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    btn = 12'hFFF;
    pad_sel = 1'b1;
    sel_t = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_checks++;
      if ({pad_out, phase} !== {6'h3F, 3'd0}) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: pad_out=%b phase=%0d, want 111111/0", i, pad_out, phase);
      end
      n_checks++;
      if ({pad_out3, phase3} !== {6'h3F, 3'd0}) begin
        n_fail++;
        $display("FAIL reset_hold3[%0d]: pad_out=%b phase=%0d, want 111111/0", i, pad_out3, phase3);
      end
    end
    reset = 1'b0;
    n_checks++;
    if ({pad_out, ext_active} !== {6'h3F, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_first_cycle: pad_out=%b ext=%b, want 111111/0", pad_out, ext_active);
    end
    tick(3);
    n_checks++;
    if ({pad_out, phase} !== {6'h00, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_release: pad_out=%b phase=%0d, want 000000/0", pad_out, phase);
    end
  endtask

  task automatic test_six_button;
    btn = B1;
    for (int i = 0; i < 4; i++) begin
      pad_sel = 1'b0;
      tick(4);
      n_checks++;
      if ({pad_out, phase, ext_active} !== {SIX_LOW[i], SIX_PH[i], 1'b0}) begin
        n_fail++;
        $display("FAIL six_low[%0d]: pad_out=%b phase=%0d ext=%b, want %b/%0d/0",
                 i, pad_out, phase, ext_active, SIX_LOW[i], SIX_PH[i]);
      end
      tick(16);
      pad_sel = 1'b1;
      tick(4);
      n_checks++;
      if ({pad_out, phase, ext_active} !== {SIX_HIGH[i], SIX_PH[i], SIX_EXT[i]}) begin
        n_fail++;
        $display("FAIL six_high[%0d]: pad_out=%b phase=%0d ext=%b, want %b/%0d/%b",
                 i, pad_out, phase, ext_active, SIX_HIGH[i], SIX_PH[i], SIX_EXT[i]);
      end
      tick(16);
    end
  endtask

  // Entered 40 clocks after the last SELECT fall of test_six_button.
  task automatic test_timeout;
    tick(TO + 1 - 40);
    n_checks++;
    if (phase !== 3'd4) begin
      n_fail++;
      $display("FAIL timeout_before: phase=%0d, want 4", phase);
    end
    tick(1);
    n_checks++;
    if ({pad_out, phase} !== {HIGH_STD, 3'd0}) begin
      n_fail++;
      $display("FAIL timeout_expired: pad_out=%b phase=%0d, want %b/0", pad_out, phase, HIGH_STD);
    end
    pad_sel = 1'b0;
    tick(4);
    n_checks++;
    if ({pad_out, phase} !== {LOW_STD, 3'd1}) begin
      n_fail++;
      $display("FAIL timeout_next_low: pad_out=%b phase=%0d, want %b/1", pad_out, phase, LOW_STD);
    end
    pad_sel = 1'b1;
    tick(20);
  endtask

  task automatic test_edge_at_expiry;
    btn = B1;
    sel_t = 1'b0;
    tick(4);
    sel_t = 1'b1;
    tick(4);
    sel_t = 1'b0;
    tick(4);
    n_checks++;
    if (phase_t !== 3'd2) begin
      n_fail++;
      $display("FAIL expiry_setup: phase=%0d, want 2", phase_t);
    end
    sel_t = 1'b1;
    tick(TO_SHORT - 1 - 4);
    sel_t = 1'b0;
    tick(4);
    n_checks++;
    if ({pad_out_t, phase_t} !== {LOW_ID, 3'd3}) begin
      n_fail++;
      $display("FAIL expiry_edge_wins: pad_out=%b phase=%0d, want %b/3", pad_out_t, phase_t, LOW_ID);
    end
    tick(TO_SHORT + 1 - 4);
    n_checks++;
    if (phase_t !== 3'd3) begin
      n_fail++;
      $display("FAIL expiry_restart_hold: phase=%0d, want 3", phase_t);
    end
    tick(1);
    n_checks++;
    if ({pad_out_t, phase_t} !== {LOW_STD, 3'd0}) begin
      n_fail++;
      $display("FAIL expiry_restart_end: pad_out=%b phase=%0d, want %b/0", pad_out_t, phase_t, LOW_STD);
    end
    sel_t = 1'b1;
    tick(4);
  endtask

  task automatic test_three_button;
    btn = B1;
    pad_sel = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      pad_sel = 1'b0;
      tick(4);
      n_checks++;
      if ({pad_out3, phase3, ext_active3} !== {LOW_STD, TRI_PH[i], 1'b0}) begin
        n_fail++;
        $display("FAIL tri_low[%0d]: pad_out=%b phase=%0d ext=%b, want %b/%0d/0",
                 i, pad_out3, phase3, ext_active3, LOW_STD, TRI_PH[i]);
      end
      tick(16);
      pad_sel = 1'b1;
      tick(4);
      n_checks++;
      if ({pad_out3, phase3, ext_active3} !== {HIGH_STD, TRI_PH[i], 1'b0}) begin
        n_fail++;
        $display("FAIL tri_high[%0d]: pad_out=%b phase=%0d ext=%b, want %b/%0d/0",
                 i, pad_out3, phase3, ext_active3, HIGH_STD, TRI_PH[i]);
      end
      tick(16);
    end
  endtask

  task automatic test_reset_mid;
    btn = B1;
    pad_sel = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      pad_sel = 1'b0;
      tick(10);
      pad_sel = 1'b1;
      tick(i == 2 ? 4 : 10);
    end
    n_checks++;
    if ({phase, ext_active} !== {3'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_setup: phase=%0d ext=%b, want 3/1", phase, ext_active);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_checks++;
    if ({pad_out, phase, ext_active} !== {6'h3F, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: pad_out=%b phase=%0d ext=%b, want 111111/0/0", pad_out, phase, ext_active);
    end
    tick(3);
    pad_sel = 1'b0;
    tick(4);
    n_checks++;
    if ({pad_out, phase} !== {LOW_STD, 3'd1}) begin
      n_fail++;
      $display("FAIL mid_first_low: pad_out=%b phase=%0d, want %b/1", pad_out, phase, LOW_STD);
    end
  endtask

  task automatic test_btn_latency;
    pad_sel = 1'b1;
    tick(5);
    n_checks++;
    if (pad_out !== HIGH_STD) begin
      n_fail++;
      $display("FAIL btn_before: pad_out=%b, want %b", pad_out, HIGH_STD);
    end
    btn = 12'h000;
    tick(1);
    n_checks++;
    if (pad_out !== 6'h3F) begin
      n_fail++;
      $display("FAIL btn_one_clock: pad_out=%b, want 111111", pad_out);
    end
  endtask

  initial begin
    test_reset;
    test_six_button;
    test_timeout;
    test_edge_at_expiry;
    test_three_button;
    test_reset_mid;
    test_btn_latency;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
